// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer.
// Borrows the core ALU for the per-iteration add; fixed 35-cycle latency.
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic            alu_mod,
  input  logic [XLEN-1:0] alu_res
);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIX
  } state_t;

  state_t state, state_n;

  logic [2:0]        op;
  logic [XLEN-1:0]   ra, rb;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   lo;
  logic              neg;
  logic [4:0]        cnt;

  logic              is_div;
  logic              sgn_a, sgn_b, neg_n;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     rp;
  logic              carry, take;
  logic [2*XLEN-1:0] prod, prodn;
  logic [XLEN-1:0]   val, valn, fix_res;

  assign is_div = op[2];

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    neg_n = 1'b0;
    unique case (op)
      3'd1: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
        neg_n = ra[XLEN-1] ^ rb[XLEN-1];
      end
      3'd2: begin
        sgn_a = 1'b1;
        neg_n = ra[XLEN-1];
      end
      3'd4: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
        neg_n = (ra[XLEN-1] ^ rb[XLEN-1]) & (|rb);
      end
      3'd6: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
        neg_n = ra[XLEN-1];
      end
      default: ;
    endcase
  end

  assign abs_a = (sgn_a && ra[XLEN-1]) ? -ra : ra;
  assign abs_b = (sgn_b && rb[XLEN-1]) ? -rb : rb;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = 3'd0;
    alu_mod = 1'b0;
    if (state == ITER) begin
      if (is_div) begin
        alu_a = rp[XLEN-1:0];
        alu_b = ~opnd + XLEN'(1);
      end else begin
        alu_a = acc;
        alu_b = lo[0] ? opnd : '0;
      end
    end
  end

  // Negating a zero divisor wraps to 0 and loses the carry; force it.
  assign rp    = {acc, lo[XLEN-1]};
  assign carry = alu_res < alu_a;
  assign take  = rp[XLEN] | carry | (opnd == '0);

  always_comb begin
    prod    = {acc, lo};
    prodn   = neg ? -prod : prod;
    val     = op[1] ? acc : lo;
    valn    = neg ? -val : val;
    fix_res = '0;
    if (is_div) fix_res = valn;
    else if (op == 3'd0) fix_res = prodn[XLEN-1:0];
    else fix_res = prodn[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    unique case (state)
      IDLE: if (start) state_n = PREP;
      PREP: state_n = ITER;
      ITER: if (cnt == 5'(ITERS-1)) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      res  <= '0;
      op   <= 3'd0;
      ra   <= '0;
      rb   <= '0;
      opnd <= '0;
      acc  <= '0;
      lo   <= '0;
      neg  <= 1'b0;
      cnt  <= 5'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op <= funct3;
            ra <= a;
            rb <= b;
          end
        end
        PREP: begin
          acc  <= '0;
          cnt  <= 5'd0;
          neg  <= neg_n;
          lo   <= is_div ? abs_a : abs_b;
          opnd <= is_div ? abs_b : abs_a;
        end
        ITER: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            acc <= take ? alu_res : rp[XLEN-1:0];
            lo  <= {lo[XLEN-2:0], take};
          end else begin
            acc <= {carry, alu_res[XLEN-1:1]};
            lo  <= {alu_res[0], lo[XLEN-1:1]};
          end
        end
        FIX: begin
          res  <= fix_res;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
